// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: valid/ready pipeline register stage with a saturating stall counter.
// Define PIPE_LATCH_SKID_EN for a 2-deep main+skid build whose in_ready is a flop output.
module pipe_stage_latch #(
   parameter int PC_W = 32,
   parameter int INSTR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_OPS = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic                      clock,
   input  logic                      res,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PC_W-1:0]           in_pc,
   input  logic [INSTR_W-1:0]        in_instr,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PC_W-1:0]           out_pc,
   output logic [INSTR_W-1:0]        out_instr,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [15:0]               stall_cnt
);
   localparam int OPS_W = NUM_OPS * DATA_W;
   logic               m_valid_q, m_valid_d;
   logic [PC_W-1:0]    m_pc_q, m_pc_d;
   logic [INSTR_W-1:0] m_instr_q, m_instr_d;
   logic [OPS_W-1:0]   m_ops_q, m_ops_d;
   logic [15:0]        stall_q, stall_d;
   logic               in_xfer;
   assign out_valid = m_valid_q;
   assign out_pc    = m_valid_q ? m_pc_q : '0;
   assign out_instr = m_valid_q ? m_instr_q : NOP_INSTR;
   assign out_ops   = m_valid_q ? m_ops_q : '0;
   assign stall_cnt = stall_q;
   assign in_xfer   = in_valid && in_ready;
   always_comb
      stall_d = flush ? 16'd0 :
                (m_valid_q && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
   always_ff @(posedge clock or negedge res)
      if (!res) begin
         m_valid_q <= 1'b0;
         m_pc_q    <= '0;
         m_instr_q <= NOP_INSTR;
         m_ops_q   <= '0;
         stall_q   <= 16'd0;
      end else begin
         m_valid_q <= m_valid_d;
         m_pc_q    <= m_pc_d;
         m_instr_q <= m_instr_d;
         m_ops_q   <= m_ops_d;
         stall_q   <= stall_d;
      end
`ifdef PIPE_LATCH_SKID_EN
   logic               s_valid_q, s_valid_d;
   logic [PC_W-1:0]    s_pc_q, s_pc_d;
   logic [INSTR_W-1:0] s_instr_q, s_instr_d;
   logic [OPS_W-1:0]   s_ops_q, s_ops_d;
   assign in_ready = !s_valid_q;
   always_comb begin
      m_valid_d = m_valid_q;
      m_pc_d    = m_pc_q;
      m_instr_d = m_instr_q;
      m_ops_d   = m_ops_q;
      s_valid_d = s_valid_q;
      s_pc_d    = s_pc_q;
      s_instr_d = s_instr_q;
      s_ops_d   = s_ops_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (m_valid_q && !out_ready) begin
         // main is stalled: a new entry can only park in skid
         if (in_xfer) begin
            s_valid_d = 1'b1;
            s_pc_d    = in_pc;
            s_instr_d = in_instr;
            s_ops_d   = in_ops;
         end
      end else if (s_valid_q) begin
         m_valid_d = 1'b1;
         m_pc_d    = s_pc_q;
         m_instr_d = s_instr_q;
         m_ops_d   = s_ops_q;
         s_valid_d = 1'b0;
      end else begin
         m_valid_d = in_xfer;
         if (in_xfer) begin
            m_pc_d    = in_pc;
            m_instr_d = in_instr;
            m_ops_d   = in_ops;
         end
      end
   end
   always_ff @(posedge clock or negedge res)
      if (!res) begin
         s_valid_q <= 1'b0;
         s_pc_q    <= '0;
         s_instr_q <= NOP_INSTR;
         s_ops_q   <= '0;
      end else begin
         s_valid_q <= s_valid_d;
         s_pc_q    <= s_pc_d;
         s_instr_q <= s_instr_d;
         s_ops_q   <= s_ops_d;
      end
`else
   assign in_ready = !m_valid_q || out_ready;
   always_comb begin
      m_valid_d = m_valid_q;
      m_pc_d    = m_pc_q;
      m_instr_d = m_instr_q;
      m_ops_d   = m_ops_q;
      if (flush)
         m_valid_d = 1'b0;
      else if (in_xfer) begin
         m_valid_d = 1'b1;
         m_pc_d    = in_pc;
         m_instr_d = in_instr;
         m_ops_d   = in_ops;
      end else if (m_valid_q && out_ready)
         m_valid_d = 1'b0;
   end
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: vector table, corner sequences and a queue-model random run for pipe_stage_latch.
// Builds with or without PIPE_LATCH_SKID_EN; expectations follow the selected depth.
module tb_pipe_stage_latch;
   localparam int NUM_OPS = 4;
   localparam int DATA_W = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_LATCH_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   logic        clock = 1'b0, res = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] in_pc = '0, in_instr = '0, out_pc, out_instr;
   logic [63:0] in_ops = '0, out_ops;
   logic [15:0] stall_cnt;
   int checks = 0, failures = 0;
   typedef struct {
      logic iv; logic [31:0] pc; logic ordy; logic fl;
      logic ev; logic [31:0] epc; logic eir;
   } vec_t;
   vec_t tbl[7];
   logic [31:0] q[$];
   int sc;
   always #5 clock = ~clock;
   pipe_stage_latch #(.PC_W(32), .INSTR_W(32), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .NOP_INSTR(NOP)) dut (
      .clock(clock), .res(res), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_ops(out_ops),
      .stall_cnt(stall_cnt));
   function automatic logic [63:0] ops_of(input logic [31:0] pc);
      logic [63:0] o = '0;
      for (int k = 0; k < NUM_OPS; k++) o[k*DATA_W +: DATA_W] = pc[15:0] ^ (16'(k + 1) * 16'h1111);
      return o;
   endfunction
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   task automatic check_out(input string name, input logic ev, input logic [31:0] epc);
      chk({name, ".out_valid"}, 64'(out_valid), 64'(ev));
      chk({name, ".out_pc"}, 64'(out_pc), ev ? 64'(epc) : 64'd0);
      chk({name, ".out_instr"}, 64'(out_instr), ev ? 64'(instr_of(epc)) : 64'(NOP));
      chk({name, ".out_ops"}, out_ops, ev ? ops_of(epc) : 64'd0);
   endtask
   task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
      in_valid = iv; in_pc = pc; in_instr = instr_of(pc); in_ops = ops_of(pc);
      out_ready = ordy; flush = fl;
   endtask
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask
   task automatic pulse_reset();
      #2 res = 1'b0;
      @(negedge clock);
      res = 1'b1;
   endtask
   initial begin
      drive(1'b1, 32'h55, 1'b1, 1'b0);
      tick();
      tick();
      check_out("reset", 1'b0, 32'h0);
      chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      res = 1'b1;
      tbl[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1};
      tbl[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1};
      tbl[2] = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
      tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h108, 1'b1};
      tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   1'b1};
      tbl[5] = '{1'b1, 32'h1F0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1};
      tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   1'b1};
      foreach (tbl[i]) begin
         drive(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
         #1;
         check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc);
         chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
         tick();
      end
`ifdef PIPE_LATCH_SKID_EN
      drive(1'b1, 32'h200, 1'b0, 1'b0); #1;
      chk("skid.first_ready", 64'(in_ready), 64'd1);
      tick();
      drive(1'b1, 32'h204, 1'b0, 1'b0); #1;
      check_out("skid.held", 1'b1, 32'h200);
      chk("skid.ready_to_skid", 64'(in_ready), 64'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h208, 1'b0, 1'b0); #1;
         chk("skid.full_ready", 64'(in_ready), 64'd0);
         tick();
      end
      drive(1'b1, 32'h208, 1'b1, 1'b0); #1;
      check_out("skid.release", 1'b1, 32'h200);
      chk("skid.stall_cnt", 64'(stall_cnt), 64'd5);
      chk("skid.ready_registered", 64'(in_ready), 64'd0);
      tick();
      drive(1'b1, 32'h208, 1'b1, 1'b0); #1;
      check_out("skid.second", 1'b1, 32'h204);
      chk("skid.ready_again", 64'(in_ready), 64'd1);
      chk("skid.stall_kept", 64'(stall_cnt), 64'd5);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0); #1;
      check_out("skid.third", 1'b1, 32'h208);
      tick();
      check_out("skid.drained", 1'b0, 32'h0);
`else
      drive(1'b1, 32'h200, 1'b0, 1'b0); #1;
      chk("ns.first_ready", 64'(in_ready), 64'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h204, 1'b0, 1'b0); #1;
         check_out("ns.held", 1'b1, 32'h200);
         chk("ns.ready_low", 64'(in_ready), 64'd0);
         tick();
      end
      drive(1'b1, 32'h204, 1'b1, 1'b0); #1;
      chk("ns.ready_comb", 64'(in_ready), 64'd1);
      chk("ns.stall_cnt", 64'(stall_cnt), 64'd4);
      check_out("ns.before_replace", 1'b1, 32'h200);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0); #1;
      check_out("ns.replaced", 1'b1, 32'h204);
      tick();
      check_out("ns.drained", 1'b0, 32'h0);
`endif
      drive(1'b1, 32'h2A0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h2A4, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h2A8, 1'b0, 1'b0); #1;
      chk("flush.pre_stall_nonzero", 64'(stall_cnt != 16'd0), 64'd1);
      tick();
      drive(1'b1, 32'h300, 1'b1, 1'b1); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0); #1;
      check_out("flush.after", 1'b0, 32'h0);
      chk("flush.stall_cnt", 64'(stall_cnt), 64'd0);
      chk("flush.in_ready", 64'(in_ready), 64'd1);
      tick();
      check_out("flush.dropped", 1'b0, 32'h0);
      drive(1'b1, 32'h400, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h404, 1'b0, 1'b0); tick();
      #2 res = 1'b0;
      #1;
      check_out("arst", 1'b0, 32'h0);
      chk("arst.stall_cnt", 64'(stall_cnt), 64'd0);
      chk("arst.in_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      res = 1'b1;
      drive(1'b1, 32'h500, 1'b1, 1'b0); #1;
      chk("arst.release_ready", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0); #1;
      check_out("arst.first_accept", 1'b1, 32'h500);
      tick();
      check_out("arst.empty", 1'b0, 32'h0);
      pulse_reset();
      q.delete();
      sc = 0;
      for (int n = 0; n < 3000; n++) begin
         logic iv, ordy, fl, mir;
         logic [31:0] pc;
         iv = ($urandom_range(3) != 0);
         ordy = ($urandom_range(9) < 7);
         fl = ($urandom_range(39) == 0);
         pc = $urandom;
         drive(iv, pc, ordy, fl); #1;
         mir = (DEPTH == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
         check_out("rnd", q.size() > 0, (q.size() > 0) ? q[0] : 32'h0);
         chk("rnd.in_ready", 64'(in_ready), 64'(mir));
         chk("rnd.stall_cnt", 64'(stall_cnt), 64'(sc));
         if (fl) begin
            q.delete();
            sc = 0;
         end else begin
            if (q.size() > 0 && !ordy && sc < 65535) sc++;
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && mir) q.push_back(pc);
         end
         tick();
      end
      pulse_reset();
      drive(1'b1, 32'h600, 1'b0, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (65534) @(posedge clock);
      @(negedge clock);
      chk("sat.below", 64'(stall_cnt), 64'hFFFE);
      tick();
      chk("sat.reach", 64'(stall_cnt), 64'hFFFF);
      repeat (4465) @(posedge clock);
      @(negedge clock);
      chk("sat.hold", 64'(stall_cnt), 64'hFFFF);
      check_out("sat.entry", 1'b1, 32'h600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
